// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and helpers for the 4x4 keypad scanner
package keypad_pkg;

  // Candidate: bit 4 set means "no single key this scan", else bits 3:0 hold the code
  typedef logic [4:0] cand_t;
  localparam cand_t CAND_NONE = 5'b10000;

  // Commit FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Active-low column drive, nibble c drives column c
  localparam logic [15:0] COL_PATTERNS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Key codes, nibble index = r*4 + c
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return COL_PATTERNS[{c, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEYMAP[{r, c, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - scan-level debounce and commit FSM (KEYPAD_AUTOREPEAT_EN adds repeat strobes)
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DB_COUNT     = 3,
  parameter int REPEAT_SCANS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cand,
  input  logic       scan_done,
  output logic [3:0] key,
  output logic       valid,
  output logic       press
);

  localparam int SW = (DB_COUNT > 1) ? $clog2(DB_COUNT + 1) : 1;

  if (DB_COUNT < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("key_debounce: DB_COUNT and REPEAT_SCANS must be at least 1");
  end

  logic [4:0]    prev;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_next;
  logic [0:0]    state;
  logic          commit;
  logic          is_key;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS + 1) : 1;
  logic [RW-1:0] rpt;
`endif

  // Stability count the current scan result would produce; commit uses it directly
  always_comb begin
    stable_next = SW'(1);
    if (cand == prev) begin
      stable_next = (stable == SW'(DB_COUNT)) ? stable : stable + SW'(1);
    end
  end

  assign commit = scan_done && (stable_next == SW'(DB_COUNT));
  assign is_key = ~cand[4];

  // Debounce history plus commit FSM; press defaults low so it is a single-cycle strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= CAND_NONE;
      stable <= '0;
      state  <= ST_IDLE;
      key    <= 4'h0;
      valid  <= 1'b0;
      press  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt    <= '0;
`endif
    end else begin
      press <= 1'b0;
      if (scan_done) begin
        prev   <= cand;
        stable <= stable_next;
        if (state == ST_IDLE) begin
          if (commit && is_key) begin
            state <= ST_HELD;
            key   <= cand[3:0];
            valid <= 1'b1;
            press <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt   <= '0;
`endif
          end
        end else begin
          if (commit && !is_key) begin
            state <= ST_IDLE;
            valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt   <= '0;
`endif
          end else if (commit && cand[3:0] != key) begin
            key   <= cand[3:0];
            press <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt   <= '0;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rpt == RW'(REPEAT_SCANS - 1)) begin
            press <= 1'b1;
            rpt   <= '0;
          end else begin
            rpt <= rpt + RW'(1);
          end
`endif
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner top (optional KEYPAD_AUTOREPEAT_EN)
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int COL_BITS     = 16,
  parameter int DB_COUNT     = 3,
  parameter int REPEAT_SCANS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       valid,
  output logic       press
);

  logic [COL_BITS+1:0] s;
  logic [1:0]          col_sel;
  logic                sample;
  logic                scan_done;
  logic [1:0]          acc_count;
  logic [3:0]          acc_code;
  logic [1:0]          hits;
  logic [3:0]          hit_code;
  logic [2:0]          sum;
  logic [1:0]          next_count;
  logic [4:0]          cand;

  assign col_sel   = s[COL_BITS+1:COL_BITS];
  assign sample    = &s[COL_BITS-1:0];
  assign scan_done = sample && (col_sel == 2'd3);
  assign col       = col_drive(col_sel);

  // Fold this column's row sample into the running scan tally
  always_comb begin
    hits     = 2'd0;
    hit_code = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        hit_code = key_code(2'(r), col_sel);
        if (hits != 2'd2) hits = hits + 2'd1;
      end
    end
    sum        = {1'b0, acc_count} + {1'b0, hits};
    next_count = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    cand       = (next_count == 2'd1) ? {1'b0, hit_code} : CAND_NONE;
  end

  // Scan counter and per-scan accumulators; cleared after column 3 so each scan starts fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      acc_count <= 2'd0;
      acc_code  <= 4'h0;
    end else begin
      s <= s + 1'b1;
      if (sample) begin
        if (scan_done) begin
          acc_count <= 2'd0;
          acc_code  <= 4'h0;
        end else begin
          acc_count <= next_count;
          acc_code  <= hit_code;
        end
      end
    end
  end

  key_debounce #(
    .DB_COUNT     (DB_COUNT),
    .REPEAT_SCANS (REPEAT_SCANS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .cand      (cand),
    .scan_done (scan_done),
    .key       (key),
    .valid     (valid),
    .press     (press)
  );

endmodule
